// File: rtl/conv_input_interface_if.sv
// Command/ack, image-ROM and kernel-array signals of the conv input stage.
// Optional status signals (busy, drop_cnt) exist only when CONV_INPUT_STATUS_EN is defined.
interface conv_input_interface_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ARRAY_SIZE = 6,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic [1:0]                  cmd;
    logic [1:0]                  ack;
    logic                        rom_en;
    logic [ADDR_WIDTH-1:0]       rom_addr;
    logic [WIDTH-1:0]            rom_data;
    logic [ARRAY_SIZE*WIDTH-1:0] array_data;
    logic                        array_valid;
    logic                        frame_done;
`ifdef CONV_INPUT_STATUS_EN
    logic                        busy;
    logic [7:0]                  drop_cnt;

    modport master (
        output cmd, rom_data,
        input  ack, rom_en, rom_addr, array_data, array_valid, frame_done, busy, drop_cnt
    );
    modport slave (
        input  cmd, rom_data,
        output ack, rom_en, rom_addr, array_data, array_valid, frame_done, busy, drop_cnt
    );
`else
    modport master (
        output cmd, rom_data,
        input  ack, rom_en, rom_addr, array_data, array_valid, frame_done
    );
    modport slave (
        input  cmd, rom_data,
        output ack, rom_en, rom_addr, array_data, array_valid, frame_done
    );
`endif
endinterface

// File: rtl/conv_input_interface.sv
// Conv-layer input stage: executes PRELOAD/SHIFT/LOAD commands over a circular line buffer.
// Define CONV_INPUT_STATUS_EN to add the busy / drop_cnt status outputs.
module conv_input_interface #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned IMAGE_SIZE  = 8,
    parameter int unsigned ARRAY_SIZE  = 6,
    parameter int unsigned ADDR_WIDTH  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    conv_input_interface_if.slave  io
);
    localparam int unsigned ROW_W     = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int unsigned ROW_SUM_W = ROW_W + 1;
    localparam int unsigned COL_W     = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int unsigned NROW_W    = $clog2(IMAGE_SIZE + 1);
    localparam int unsigned WIN_W     = ARRAY_SIZE * WIDTH;

    localparam logic [1:0] CMD_IDLE    = 2'd0;
    localparam logic [1:0] CMD_PRELOAD = 2'd1;
    localparam logic [1:0] CMD_SHIFT   = 2'd2;
    localparam logic [1:0] CMD_LOAD    = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_PRELOAD, ST_SHIFT, ST_LOAD} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             ack_q, ack_d;
    logic                   rom_en_q, rom_en_d;
    logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic [WIN_W-1:0]       array_data_q, array_data_d;
    logic                   array_valid_q, array_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic [ROW_W-1:0]       rd_prow_q, rd_prow_d;
    logic [COL_W-1:0]       rd_col_q, rd_col_d;
    logic                   wr_vld_q, wr_vld_d;
    logic                   wr_last_q, wr_last_d;
    logic [ROW_W-1:0]       wr_prow_q, wr_prow_d;
    logic [COL_W-1:0]       wr_col_q, wr_col_d;
    logic [ROW_W-1:0]       sh_col_q, sh_col_d;
    logic [NROW_W-1:0]      next_row_q, next_row_d;
    logic [ROW_W-1:0]       shift_row_q, shift_row_d;
    logic [ROW_W-1:0]       oldest_q, oldest_d;
    logic [WIDTH-1:0]       lbuf_q [KERNEL_SIZE][IMAGE_SIZE];

    logic                   rd_last_c;
    logic [ROW_SUM_W-1:0]   row_sum_c;
    logic [ROW_W-1:0]       phys_row_c;
    logic [ROW_W-1:0]       win_col_c;
    logic [WIN_W-1:0]       win_c;

    function automatic logic [ROW_W-1:0] wrap_inc(input logic [ROW_W-1:0] x);
        return (x == ROW_W'(KERNEL_SIZE - 1)) ? '0 : x + ROW_W'(1);
    endfunction

    // Last ROM read of the current fill: end of the single LOAD row, or of the last PRELOAD row.
    assign rd_last_c = (rd_col_q == COL_W'(IMAGE_SIZE - 1)) &&
                       ((state_q == ST_LOAD) || (rd_prow_q == ROW_W'(KERNEL_SIZE - 1)));

    // Window for the next SHIFT beat: logical row shift_row maps to physical row via oldest pointer.
    always_comb begin
        row_sum_c  = {1'b0, oldest_q} + {1'b0, shift_row_q};
        phys_row_c = (row_sum_c >= ROW_SUM_W'(KERNEL_SIZE))
                   ? ROW_W'(row_sum_c - ROW_SUM_W'(KERNEL_SIZE)) : ROW_W'(row_sum_c);
        win_col_c  = (state_q == ST_SHIFT) ? sh_col_q + ROW_W'(1) : '0;
        win_c      = '0;
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            win_c[j*WIDTH +: WIDTH] = lbuf_q[phys_row_c][COL_W'(win_col_c) + COL_W'(j)];
        end
    end

    always_comb begin
        state_d       = state_q;
        ack_d         = 2'd0;
        rom_en_d      = 1'b0;
        rom_addr_d    = rom_addr_q;
        array_data_d  = array_data_q;
        array_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        rd_prow_d     = rd_prow_q;
        rd_col_d      = rd_col_q;
        wr_vld_d      = 1'b0;
        wr_last_d     = 1'b0;
        wr_prow_d     = wr_prow_q;
        wr_col_d      = wr_col_q;
        sh_col_d      = sh_col_q;
        next_row_d    = next_row_q;
        shift_row_d   = shift_row_q;
        oldest_d      = oldest_q;

        unique case (state_q)
            ST_IDLE: begin
                case (io.cmd)
                    CMD_PRELOAD: begin
                        state_d    = ST_PRELOAD;
                        rom_en_d   = 1'b1;
                        rom_addr_d = '0;
                        rd_prow_d  = '0;
                        rd_col_d   = '0;
                        oldest_d   = '0;
                    end
                    CMD_SHIFT: begin
                        state_d       = ST_SHIFT;
                        sh_col_d      = '0;
                        array_valid_d = 1'b1;
                        array_data_d  = win_c;
                    end
                    CMD_LOAD: begin
                        if (next_row_q < NROW_W'(IMAGE_SIZE)) begin
                            state_d    = ST_LOAD;
                            rom_en_d   = 1'b1;
                            rom_addr_d = ADDR_WIDTH'(next_row_q * IMAGE_SIZE);
                            rd_prow_d  = oldest_q;
                            rd_col_d   = '0;
                        end else begin
                            ack_d        = CMD_LOAD;
                            frame_done_d = 1'b1;
                            next_row_d   = '0;
                        end
                    end
                    default: ;
                endcase
            end
            ST_PRELOAD, ST_LOAD: begin
                // Read issued this cycle is written next cycle when rom_data is valid.
                if (rom_en_q) begin
                    wr_vld_d  = 1'b1;
                    wr_prow_d = rd_prow_q;
                    wr_col_d  = rd_col_q;
                    wr_last_d = rd_last_c;
                    if (!rd_last_c) begin
                        rom_en_d   = 1'b1;
                        rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
                        if (rd_col_q == COL_W'(IMAGE_SIZE - 1)) begin
                            rd_col_d  = '0;
                            rd_prow_d = rd_prow_q + ROW_W'(1);
                        end else begin
                            rd_col_d  = rd_col_q + COL_W'(1);
                        end
                    end
                end
                if (wr_last_q) begin
                    state_d     = ST_IDLE;
                    shift_row_d = '0;
                    if (state_q == ST_PRELOAD) begin
                        ack_d      = CMD_PRELOAD;
                        next_row_d = NROW_W'(KERNEL_SIZE);
                    end else begin
                        ack_d      = CMD_LOAD;
                        oldest_d   = wrap_inc(oldest_q);
                        next_row_d = next_row_q + NROW_W'(1);
                    end
                end
            end
            ST_SHIFT: begin
                if (sh_col_q == ROW_W'(KERNEL_SIZE - 1)) begin
                    state_d     = ST_IDLE;
                    ack_d       = CMD_SHIFT;
                    shift_row_d = wrap_inc(shift_row_q);
                end else begin
                    sh_col_d      = sh_col_q + ROW_W'(1);
                    array_valid_d = 1'b1;
                    array_data_d  = win_c;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ack_q         <= 2'd0;
            rom_en_q      <= 1'b0;
            rom_addr_q    <= '0;
            array_data_q  <= '0;
            array_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            rd_prow_q     <= '0;
            rd_col_q      <= '0;
            wr_vld_q      <= 1'b0;
            wr_last_q     <= 1'b0;
            wr_prow_q     <= '0;
            wr_col_q      <= '0;
            sh_col_q      <= '0;
            next_row_q    <= '0;
            shift_row_q   <= '0;
            oldest_q      <= '0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            rom_en_q      <= rom_en_d;
            rom_addr_q    <= rom_addr_d;
            array_data_q  <= array_data_d;
            array_valid_q <= array_valid_d;
            frame_done_q  <= frame_done_d;
            rd_prow_q     <= rd_prow_d;
            rd_col_q      <= rd_col_d;
            wr_vld_q      <= wr_vld_d;
            wr_last_q     <= wr_last_d;
            wr_prow_q     <= wr_prow_d;
            wr_col_q      <= wr_col_d;
            sh_col_q      <= sh_col_d;
            next_row_q    <= next_row_d;
            shift_row_q   <= shift_row_d;
            oldest_q      <= oldest_d;
        end
    end

    // Line buffer storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < IMAGE_SIZE; c++) begin
                    lbuf_q[r][c] <= '0;
                end
            end
        end else if (wr_vld_q) begin
            lbuf_q[wr_prow_q][wr_col_q] <= io.rom_data;
        end
    end

    assign io.ack         = ack_q;
    assign io.rom_en      = rom_en_q;
    assign io.rom_addr    = rom_addr_q;
    assign io.array_data  = array_data_q;
    assign io.array_valid = array_valid_q;
    assign io.frame_done  = frame_done_q;

`ifdef CONV_INPUT_STATUS_EN
    logic       busy_q;
    logic [7:0] drop_cnt_q;

    // Commands arriving outside IDLE are dropped; count them, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            busy_q <= (state_d != ST_IDLE);
            if ((state_q != ST_IDLE) && (io.cmd != CMD_IDLE) && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign io.busy     = busy_q;
    assign io.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_conv_input_interface.sv
// Self-checking bench for conv_input_interface against a row-queue model of the line buffer.
module tb_conv_input_interface;
    localparam int unsigned W  = 32;
    localparam int unsigned K  = 3;
    localparam int unsigned I  = 8;
    localparam int unsigned A  = 6;
    localparam int unsigned AW = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_input_interface_if #(.WIDTH(W), .ARRAY_SIZE(A), .ADDR_WIDTH(AW)) io();

    conv_input_interface #(
        .WIDTH(W), .KERNEL_SIZE(K), .IMAGE_SIZE(I), .ARRAY_SIZE(A), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io(io)
    );

    logic [W-1:0] rom [I*I];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) io.rom_data <= '0;
        else if (io.rom_en) io.rom_data <= rom[io.rom_addr];
    end

    // Model: buffered image rows, oldest first; each entry is a snapshot of a full image row.
    logic [I*W-1:0] mrows[$];
    int m_next;
    int m_shift;
    int total;
    int bad;

    function automatic logic [I*W-1:0] img_row(input int r);
        logic [I*W-1:0] v;
        for (int c = 0; c < I; c++) v[c*W +: W] = rom[r*I + c];
        return v;
    endfunction

    task automatic model_reset;
        mrows.delete();
        for (int r = 0; r < K; r++) mrows.push_back('0);
        m_next  = 0;
        m_shift = 0;
    endtask

    task automatic test_reset;
        io.cmd = 2'd0;
        rst_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({io.ack, io.rom_en, io.array_valid, io.frame_done} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {io.ack, io.rom_en, io.array_valid, io.frame_done});
        end
        total++;
        if (io.rom_addr !== '0) begin bad++; $display("FAIL reset_addr got=%0h want=0", io.rom_addr); end
        total++;
        if (io.array_data !== '0) begin bad++; $display("FAIL reset_data got=%0h want=0", io.array_data); end
`ifdef CONV_INPUT_STATUS_EN
        total++;
        if ({io.busy, io.drop_cnt} !== 9'd0) begin bad++; $display("FAIL reset_status got=%0h want=0", {io.busy, io.drop_cnt}); end
`endif
        rst_n = 1'b1;
        model_reset();
    endtask

    // ign_at != 0 puts a SHIFT command on the bus at that cycle of the preload; it must be ignored.
    task automatic test_preload(input int ign_at);
        logic       exp_en;
        logic [1:0] exp_ack;
        io.cmd = 2'd1;
        for (int k = 1; k <= int'(K*I) + 2; k++) begin
            @(negedge clk);
            io.cmd  = (k == ign_at) ? 2'd2 : 2'd0;
            exp_en  = (k <= int'(K*I));
            exp_ack = (k == int'(K*I) + 2) ? 2'd1 : 2'd0;
            total++;
            if (io.rom_en !== exp_en) begin bad++; $display("FAIL preload_en k=%0d got=%b want=%b", k, io.rom_en, exp_en); end
            if (exp_en) begin
                total++;
                if (io.rom_addr !== AW'(k-1)) begin bad++; $display("FAIL preload_addr k=%0d got=%0d want=%0d", k, io.rom_addr, k-1); end
            end
            total++;
            if (io.ack !== exp_ack) begin bad++; $display("FAIL preload_ack k=%0d got=%0d want=%0d", k, io.ack, exp_ack); end
            total++;
            if (io.array_valid !== 1'b0) begin bad++; $display("FAIL preload_valid k=%0d got=%b want=0", k, io.array_valid); end
`ifdef CONV_INPUT_STATUS_EN
            total++;
            if (io.busy !== (k <= int'(K*I) + 1)) begin bad++; $display("FAIL preload_busy k=%0d got=%b", k, io.busy); end
`endif
        end
        io.cmd = 2'd0;
        mrows.delete();
        for (int r = 0; r < int'(K); r++) mrows.push_back(img_row(r));
        m_next  = K;
        m_shift = 0;
    endtask

    task automatic test_shift;
        logic [I*W-1:0] rowv;
        logic [A*W-1:0] exp_win;
        logic [1:0]     exp_ack;
        rowv   = mrows[m_shift];
        io.cmd = 2'd2;
        for (int k = 1; k <= int'(K) + 1; k++) begin
            @(negedge clk);
            io.cmd = 2'd0;
            if (k <= int'(K)) begin
                for (int j = 0; j < int'(A); j++) exp_win[j*W +: W] = rowv[(k-1+j)*W +: W];
            end
            exp_ack = (k == int'(K) + 1) ? 2'd2 : 2'd0;
            total++;
            if (io.array_valid !== (k <= int'(K))) begin bad++; $display("FAIL shift_valid k=%0d got=%b", k, io.array_valid); end
            total++;
            if (io.array_data !== exp_win) begin bad++; $display("FAIL shift_data k=%0d row=%0d got=%0h want=%0h", k, m_shift, io.array_data, exp_win); end
            total++;
            if (io.ack !== exp_ack) begin bad++; $display("FAIL shift_ack k=%0d got=%0d want=%0d", k, io.ack, exp_ack); end
            total++;
            if (io.rom_en !== 1'b0) begin bad++; $display("FAIL shift_rom_en k=%0d got=%b want=0", k, io.rom_en); end
        end
        m_shift = (m_shift + 1) % K;
    endtask

    task automatic test_load;
        logic       exp_en;
        logic [1:0] exp_ack;
        io.cmd = 2'd3;
        if (m_next < int'(I)) begin
            for (int k = 1; k <= int'(I) + 2; k++) begin
                @(negedge clk);
                io.cmd  = 2'd0;
                exp_en  = (k <= int'(I));
                exp_ack = (k == int'(I) + 2) ? 2'd3 : 2'd0;
                total++;
                if (io.rom_en !== exp_en) begin bad++; $display("FAIL load_en k=%0d got=%b want=%b", k, io.rom_en, exp_en); end
                if (exp_en) begin
                    total++;
                    if (io.rom_addr !== AW'(m_next*I + k - 1)) begin
                        bad++; $display("FAIL load_addr k=%0d got=%0d want=%0d", k, io.rom_addr, m_next*I + k - 1);
                    end
                end
                total++;
                if (io.ack !== exp_ack) begin bad++; $display("FAIL load_ack k=%0d got=%0d want=%0d", k, io.ack, exp_ack); end
                total++;
                if (io.frame_done !== 1'b0) begin bad++; $display("FAIL load_frame_done k=%0d got=%b want=0", k, io.frame_done); end
            end
            void'(mrows.pop_front());
            mrows.push_back(img_row(m_next));
            m_next++;
            m_shift = 0;
        end else begin
            @(negedge clk);
            io.cmd = 2'd0;
            total++;
            if ({io.ack, io.frame_done, io.rom_en} !== 4'b1110) begin
                bad++; $display("FAIL frame_end got ack=%0d fd=%b en=%b want ack=3 fd=1 en=0", io.ack, io.frame_done, io.rom_en);
            end
            @(negedge clk);
            total++;
            if ({io.ack, io.frame_done, io.rom_en} !== 4'b0000) begin
                bad++; $display("FAIL frame_end_pulse got ack=%0d fd=%b en=%b want all 0", io.ack, io.frame_done, io.rom_en);
            end
            m_next = 0;
        end
    endtask

    task automatic test_ignored_cmd;
        test_preload(5);
`ifdef CONV_INPUT_STATUS_EN
        total++;
        if (io.drop_cnt !== 8'd1) begin bad++; $display("FAIL drop_cnt got=%0d want=1", io.drop_cnt); end
`endif
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 4; n++) test_shift();
    endtask

    task automatic test_frame_end;
        while (m_next < int'(I)) test_load();
        test_load();
        test_shift();
        test_preload(0);
        test_shift();
    endtask

    task automatic test_reset_mid_load;
        io.cmd = 2'd3;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            io.cmd = 2'd0;
            total++;
            if (io.rom_en !== 1'b1) begin bad++; $display("FAIL midload_en k=%0d got=%b want=1", k, io.rom_en); end
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({io.ack, io.rom_en, io.array_valid, io.frame_done, io.rom_addr} !== '0) begin
            bad++; $display("FAIL midload_reset got ack=%0d en=%b addr=%0d", io.ack, io.rom_en, io.rom_addr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({io.ack, io.rom_en} !== 3'b000) begin bad++; $display("FAIL midload_no_ack k=%0d got ack=%0d en=%b", k, io.ack, io.rom_en); end
        end
        total++;
        if (io.array_data !== '0) begin bad++; $display("FAIL midload_data got=%0h want=0", io.array_data); end
        rst_n = 1'b1;
        model_reset();
        test_shift();
        test_preload(0);
        test_shift();
    endtask

    task automatic test_random;
        int op;
        for (int a = 0; a < int'(I*I); a++) rom[a] = $urandom;
        test_preload(0);
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op = $urandom_range(0, 9);
            if (op == 0) test_preload(($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0);
            else if (op <= 5) test_shift();
            else test_load();
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        io.cmd = 2'd0;
        for (int a = 0; a < int'(I*I); a++) rom[a] = W'(a);
        test_reset();
        test_shift();
        test_ignored_cmd();
        test_shift();
        test_back_to_back();
        test_load();
        test_shift();
        test_frame_end();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
